rr_arb21: RTL and testbench
===========================

// Module: rr_arb21
// PURPOSE
//  Two-requester round-robin arbiter that shares the 2:1 data mux (mux21) between sources A and B.
//  - Owns the mux select.
//  - Grants one source at a time with a req/gnt/last handshake.
//  - Registers the selected word onto y with a valid strobe.
//  - Sits between two producers and a single downstream consumer of y.
// PARAMETERS
//  WIDTH     4  data width of a, b, y
//  MAX_HOLD  8  max transfers per grant when ARB_TIMEOUT_EN is defined (>=1)
// PORTS
//  clk      in   1      rising-edge clock; single clock domain
//  rst      in   1      synchronous, active-high reset
//  req_a    in   1      A requests / is transferring
//  a        in   WIDTH  A data, sampled when gnt_a & req_a
//  last_a   in   1      final word of A's burst (qualified by gnt_a & req_a)
//  req_b    in   1      B request
//  b        in   WIDTH  B data
//  last_b   in   1      B final word
//  gnt_a    out  1      A owns the mux (registered)
//  gnt_b    out  1      B owns the mux (registered)
//  sel      out  1      mux select: 0 = a, 1 = b; equals gnt_b
//  y        out  WIDTH  registered mux output
//  y_valid  out  1      y holds a word transferred on the previous edge
// BEHAVIOUR
//  - Reset: state IDLE; gnt_a = gnt_b = sel = 0; y = 0; y_valid = 0; last_winner = B (A wins the first tie).
//    rst dominates all inputs, mid-burst included; a burst cut by reset is dropped, not resumed.
//  - States: IDLE, GRANT_A, GRANT_B (one-hot or 2-bit); gnt_a = (state == GRANT_A), gnt_b = (state == GRANT_B).
//  - IDLE:
//    - req_a only -> GRANT_A; req_b only -> GRANT_B.
//    - Both -> grant goes to the source that is not last_winner.
//    - Neither -> stay in IDLE.
//    - Latency: req seen at edge N -> gnt high after edge N.
//  - On entry to GRANT_x, last_winner <= x.
//  - GRANT_x: each cycle with req_x = 1 is one transfer; y <= x data and y_valid <= 1 at that edge.
//    Any other cycle: y_valid <= 0, y holds.
//  - Release of grant:
//    - Triggers: a transfer with last_x = 1, or req_x = 0 while granted (abort, no transfer).
//    - Other source requesting -> go directly to its GRANT state; no idle bubble, 1 cycle per handoff.
//    - Otherwise -> IDLE. The released source may re-request at once; round-robin still applies.
//  - last_x with req_x = 0 is ignored.
//  - gnt_a and gnt_b are never both 1. sel changes only on a grant edge.
//  - y is a plain WIDTH-bit copy: no arithmetic, no extension.
// CONFIGURATION
//  - Macro ARB_TIMEOUT_EN defined:
//    - A hold counter (clog2(MAX_HOLD)+1 bits) clears on grant entry and increments per transfer.
//    - On the MAX_HOLD-th transfer with the other source requesting, the grant is forcibly handed over
//      as if last were seen.
//    - If the other source is idle, the counter saturates and the grant continues.
//  - Macro not defined: no counter; a grant lasts until last or req drop; MAX_HOLD unused.
// STRUCTURE
//  - Shared include arb21_defs.vh: localparams ST_IDLE, ST_GRANT_A, ST_GRANT_B; SEL_A = 1'b0, SEL_B = 1'b1.
//  - Sub-module: the existing mux21 (a, b, sel, y) instance drives the combinational select.
//  - rr_arb21 holds the FSM, last_winner, the optional hold counter and the y/y_valid output register.
// TESTING
//  1. rst = 1 for 2 cycles with req_a = req_b = 1 -> gnt_a = gnt_b = y_valid = 0, y = 0.
//     After release: gnt_a = 1 the next cycle (A wins the first tie).
//  2. req_a = 1, a = 4'h3, 4'h5, 4'h9, last_a on the 3rd word, req_b = 0
//     -> y = 3, 5, 9 with y_valid = 1 for 3 cycles; then IDLE, gnt_a = 0.
//  3. req_a = req_b = 1 continuously with last on every word -> grants alternate A, B, A, B each cycle;
//     sel toggles 0, 1, 0, 1; y alternates a/b values.
//  4. B granted, req_b dropped mid-burst with no last, req_a = 1 -> next cycle gnt_a = 1, gnt_b = 0;
//     no y_valid on the abort cycle.
//  5. ARB_TIMEOUT_EN, MAX_HOLD = 8, A bursts 20 words with no last, req_b = 1
//     -> A is preempted after exactly 8 transfers and B is granted.
//     Without the macro: A keeps the grant for all 20 words.
//  6. rst asserted mid-burst in GRANT_B -> next cycle all outputs are at reset values.

Source files
------------

// File: rtl/rr_arb21_pkg.sv
// rr_arb21_pkg: shared arbiter state encoding and mux select values.
//   ST_IDLE / ST_GRANT_A / ST_GRANT_B : arbiter FSM states
//   SEL_A / SEL_B                      : mux select values (0 = a, 1 = b)
package rr_arb21_pkg;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_A = 2'd1,
      ST_GRANT_B = 2'd2
   } state_t;
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/rr_arb21_mux21.sv
// mux21: combinational 2:1 data select shared by the arbiter.
//   a, b : WIDTH-bit data inputs
//   sel  : SEL_A picks a, SEL_B picks b
//   y    : selected word
import rr_arb21_pkg::*;
module mux21 #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);
   assign y = (sel == SEL_B) ? b : a;
endmodule

// File: rtl/rr_arb21.sv
// rr_arb21: two-requester round-robin arbiter owning a shared 2:1 mux, with a registered output.
//   clk, rst               : clock, synchronous active-high reset
//   req_a, a, last_a       : source A request, data, final-word flag
//   req_b, b, last_b       : source B request, data, final-word flag
//   gnt_a, gnt_b           : registered one-hot grants
//   sel                    : mux select (equals gnt_b)
//   y, y_valid             : registered transferred word and its strobe
// Optional feature: define ARB_TIMEOUT_EN to force a handover after MAX_HOLD transfers
// when the other source is waiting.
import rr_arb21_pkg::*;
module rr_arb21 #(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic [WIDTH-1:0] a,
   input  logic             last_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] b,
   input  logic             last_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] y,
   output logic             y_valid
);
   state_t           state_q, state_d;
   logic             lw_q, lw_d;
   logic [WIDTH-1:0] y_q, y_d, mux_y;
   logic             yv_q, yv_d;
   logic             in_a, in_b, xfer, other, last_x, hold_hit, rel, entry;

   assign in_a   = state_q == ST_GRANT_A;
   assign in_b   = state_q == ST_GRANT_B;
   assign gnt_a  = in_a;
   assign gnt_b  = in_b;
   assign sel    = in_b ? SEL_B : SEL_A;
   assign y      = y_q;
   assign y_valid = yv_q;

   mux21 #(.WIDTH(WIDTH)) u_mux (.a(a), .b(b), .sel(sel), .y(mux_y));

   // A transfer is any granted cycle with the owner still requesting; a drop is an abort.
   assign xfer   = (in_a & req_a) | (in_b & req_b);
   assign other  = in_a ? req_b : req_a;
   assign last_x = in_a ? last_a : last_b;
   assign rel    = ~xfer | last_x | hold_hit;

   always_comb begin
      state_d = state_q;
      if (state_q == ST_IDLE)
         state_d = (req_a & (~req_b | lw_q == SEL_B)) ? ST_GRANT_A : req_b ? ST_GRANT_B : ST_IDLE;
      else if (rel)
         state_d = ~other ? ST_IDLE : in_a ? ST_GRANT_B : ST_GRANT_A;
   end

   // Grant entry covers both IDLE->GRANT and direct handovers between sources.
   assign entry = (state_d != state_q) && (state_d != ST_IDLE);
   assign lw_d  = entry ? (state_d == ST_GRANT_B ? SEL_B : SEL_A) : lw_q;
   assign y_d   = xfer ? mux_y : y_q;
   assign yv_d  = xfer;

`ifdef ARB_TIMEOUT_EN
   localparam int              HOLD_W    = $clog2(MAX_HOLD) + 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   // Saturating at MAX_HOLD keeps the preempt condition true once the limit has been reached.
   assign cnt_d    = entry ? '0 : (xfer && cnt_q != HOLD_MAX) ? cnt_q + 1'b1 : cnt_q;
   assign hold_hit = xfer & other & (cnt_q >= HOLD_LAST);
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
`else
   logic unused_hold;
   assign unused_hold = MAX_HOLD > 0;
   assign hold_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lw_q    <= SEL_B;
         y_q     <= '0;
         yv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lw_q    <= lw_d;
         y_q     <= y_d;
         yv_q    <= yv_d;
      end
   end
endmodule

// File: tb/tb_rr_arb21.sv
// tb_rr_arb21: directed self-checking bench for rr_arb21 (defaults WIDTH = 4, MAX_HOLD = 8).
module tb_rr_arb21;
   logic       clk = 1'b0;
   logic       rst, req_a, last_a, req_b, last_b;
   logic [3:0] a, b;
   logic       gnt_a, gnt_b, sel, y_valid;
   logic [3:0] y;
   int         checks = 0;
   int         errors = 0;

   rr_arb21 dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .a(a), .last_a(last_a),
      .req_b(req_b), .b(b), .last_b(last_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
      .y(y), .y_valid(y_valid)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req_a = 0; req_b = 0; last_a = 0; last_b = 0; a = 0; b = 0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset;
      idle_inputs();
      req_a = 1; req_b = 1; a = 4'hA; b = 4'hB;
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({gnt_a, gnt_b, sel, y_valid, y} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs cyc%0d: got gnt_a=%b gnt_b=%b sel=%b y_valid=%b y=%h, want all 0", i, gnt_a, gnt_b, sel, y_valid, y);
         end
      end
      rst = 0;
      tick();
      checks++;
      if ({gnt_a, gnt_b, sel, y_valid} !== 4'b1000) begin
         errors++;
         $display("FAIL first_tie: got gnt_a=%b gnt_b=%b sel=%b y_valid=%b, want 1 0 0 0", gnt_a, gnt_b, sel, y_valid);
      end
   endtask

   task automatic test_burst_a;
      logic [3:0] words [3];
      words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'h9;
      do_reset();
      req_a = 1; a = words[0];
      tick();
      checks++;
      if (gnt_a !== 1'b1 || y_valid !== 1'b0) begin
         errors++;
         $display("FAIL burst_grant: got gnt_a=%b y_valid=%b, want 1 0", gnt_a, y_valid);
      end
      for (int i = 0; i < 3; i++) begin
         a = words[i];
         last_a = (i == 2);
         tick();
         checks++;
         if (y !== words[i] || y_valid !== 1'b1 || gnt_a !== (i != 2)) begin
            errors++;
            $display("FAIL burst_word%0d: got y=%h y_valid=%b gnt_a=%b, want %h 1 %b", i, y, y_valid, gnt_a, words[i], i != 2);
         end
      end
      req_a = 0; last_a = 0;
      tick();
      checks++;
      if (y_valid !== 1'b0 || y !== 4'h9 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
         errors++;
         $display("FAIL burst_idle: got y_valid=%b y=%h gnt_a=%b gnt_b=%b, want 0 9 0 0", y_valid, y, gnt_a, gnt_b);
      end
   endtask

   task automatic test_alternate;
      logic owner_b;
      do_reset();
      req_a = 1; req_b = 1; last_a = 1; last_b = 1;
      tick();
      owner_b = 0;
      for (int i = 0; i < 4; i++) begin
         a = 4'(4'h1 + i);
         b = 4'(4'h8 + i);
         tick();
         checks++;
         if (y !== (owner_b ? 4'(4'h8 + i) : 4'(4'h1 + i)) || y_valid !== 1'b1
             || gnt_a !== owner_b || gnt_b !== !owner_b || sel !== !owner_b) begin
            errors++;
            $display("FAIL alternate%0d: got y=%h y_valid=%b gnt_a=%b gnt_b=%b sel=%b, want y=%h 1 %b %b %b",
                     i, y, y_valid, gnt_a, gnt_b, sel, owner_b ? 4'(4'h8 + i) : 4'(4'h1 + i), owner_b, !owner_b, !owner_b);
         end
         owner_b = !owner_b;
      end
   endtask

   task automatic test_abort;
      do_reset();
      req_b = 1; b = 4'h7;
      tick();
      tick();
      checks++;
      if (gnt_b !== 1'b1 || y !== 4'h7 || y_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: got gnt_b=%b y=%h y_valid=%b, want 1 7 1", gnt_b, y, y_valid);
      end
      req_b = 0; req_a = 1; a = 4'h4;
      tick();
      checks++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || sel !== 1'b0 || y_valid !== 1'b0 || y !== 4'h7) begin
         errors++;
         $display("FAIL abort_handover: got gnt_a=%b gnt_b=%b sel=%b y_valid=%b y=%h, want 1 0 0 0 7", gnt_a, gnt_b, sel, y_valid, y);
      end
   endtask

   task automatic test_timeout;
      int n;
      logic macro;
`ifdef ARB_TIMEOUT_EN
      n = 8; macro = 1;
`else
      n = 20; macro = 0;
`endif
      do_reset();
      req_a = 1; req_b = 1; b = 4'hF;
      tick();
      for (int i = 0; i < n; i++) begin
         a = 4'(i);
         tick();
         checks++;
         if (y !== 4'(i) || y_valid !== 1'b1 || gnt_a !== !(macro && i == n - 1) || gnt_b !== (macro && i == n - 1)) begin
            errors++;
            $display("FAIL hold_word%0d: got y=%h y_valid=%b gnt_a=%b gnt_b=%b, want %h 1 %b %b",
                     i, y, y_valid, gnt_a, gnt_b, 4'(i), !(macro && i == n - 1), macro && i == n - 1);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      do_reset();
      req_b = 1; b = 4'h6;
      tick();
      tick();
      checks++;
      if (gnt_b !== 1'b1 || y !== 4'h6) begin
         errors++;
         $display("FAIL midrst_pre: got gnt_b=%b y=%h, want 1 6", gnt_b, y);
      end
      rst = 1;
      tick();
      checks++;
      if ({gnt_a, gnt_b, sel, y_valid, y} !== 8'h00) begin
         errors++;
         $display("FAIL midrst_outputs: got gnt_a=%b gnt_b=%b sel=%b y_valid=%b y=%h, want all 0", gnt_a, gnt_b, sel, y_valid, y);
      end
      rst = 0; req_b = 0;
   endtask

   task automatic test_last_without_req;
      do_reset();
      req_a = 1; a = 4'h2;
      tick();
      req_a = 0; last_a = 1; req_b = 1; last_b = 1; b = 4'hC;
      tick();
      checks++;
      if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || y_valid !== 1'b0) begin
         errors++;
         $display("FAIL stray_last: got gnt_a=%b gnt_b=%b y_valid=%b, want 0 1 0", gnt_a, gnt_b, y_valid);
      end
   endtask

   initial begin
      test_reset();
      test_burst_a();
      test_alternate();
      test_abort();
      test_timeout();
      test_reset_mid_burst();
      test_last_without_req();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
